// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM encoding, digit limit
// and the per-digit clamp used on preset values.
package timer_pkg;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/bcd_down_digit.sv
// One BCD decade of the down counter; wraps 0 -> 9 and raises borrow_out
// so the next decade steps on the same edge.
module bcd_down_digit
  import timer_pkg::*;
(
  input  logic       C1K,
  input  logic       RST,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  input  logic       borrow_in,
  output logic       borrow_out,
  output logic [3:0] digit
);
  assign borrow_out = dec_en & borrow_in & (digit == 4'd0);

  always_ff @(posedge C1K or negedge RST) begin
    if (!RST)                      digit <= 4'd0;
    else if (load)                 digit <= load_val;
    else if (dec_en && borrow_in)  digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
  end
endmodule

// File: rtl/bcd_down_timer.sv
// Two-decade BCD countdown timer: load/clamp preset, run/pause FSM, one-cycle
// DONE on reaching 00, optional reload of the preset on expiry.
module bcd_down_timer
  import timer_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                  C1K,
  input  logic                  RST,
  input  logic                  CE,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  input  logic                  START,
  input  logic                  STOP,
  output logic [4*DIGITS-1:0]   VAL,
  output logic                  RUNNING,
  output logic                  DONE
);
  state_t                   state, state_nxt;
  logic [DIGITS-1:0][3:0]   preset, ld_clamped, ld_val, digs;
  logic [DIGITS:0]          borrow;
  logic                     val_zero, val_one, dec_en, reload, expire, dig_load;

  always_comb begin
    ld_clamped = '0;
    for (int i = 0; i < DIGITS; i++) ld_clamped[i] = bcd_clamp(LOAD_VAL[4*i +: 4]);
  end

  assign val_zero = (digs == '0);
  assign val_one  = (digs == (4*DIGITS)'(1));

  // Reload fires the cycle after DONE while still in RUN; it owns the digits
  // that cycle so a coincident CE cannot step below 00.
  assign reload   = AUTO_RELOAD && DONE && (state == RUN) && !LOAD;
  assign dec_en   = (state == RUN) && CE && !LOAD && !START && !STOP && !reload;
  assign expire   = dec_en && val_one;
  assign dig_load = LOAD | reload;
  assign ld_val   = LOAD ? ld_clamped : preset;

  assign borrow[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_down_digit u_dig (
      .C1K       (C1K),
      .RST       (RST),
      .load      (dig_load),
      .load_val  (ld_val[g]),
      .dec_en    (dec_en),
      .borrow_in (borrow[g]),
      .borrow_out(borrow[g+1]),
      .digit     (digs[g])
    );
  end
  assign VAL = digs;

  always_comb begin
    state_nxt = state;
    if (LOAD)
      state_nxt = IDLE;
    else if (START) begin
      if ((state == IDLE || state == PAUSE) && !val_zero) state_nxt = RUN;
    end else if (STOP) begin
      if (state == RUN) state_nxt = PAUSE;
    end else if (expire)
      state_nxt = (AUTO_RELOAD && preset != '0) ? RUN : EXPIRED;
  end

  always_ff @(posedge C1K or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      preset  <= '0;
      RUNNING <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state   <= state_nxt;
      RUNNING <= (state_nxt == RUN);
      DONE    <= expire;
      if (LOAD) preset <= ld_clamped;
    end
  end
endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Two-digit BCD countdown timer. It is the down-counting counterpart of the team's decade up-counter.
- Loads a preset value from 00 to 99, then decrements once per CE tick while running. Stops at 00 and raises a one-cycle DONE pulse.
- Sits next to the display/time-base logic. VAL feeds the 7-segment decoder directly; CE comes from the shared 1 kHz-derived tick generator.

Parameters:
- DIGITS, 2, number of cascaded BCD decades. Fixed at 2 for this revision; VAL width = 4*DIGITS.
- AUTO_RELOAD, 0, 1 = on expiry, reload the last preset and keep running instead of stopping.

Ports:
- C1K  input  1  system clock; all state updates on its rising edge.
- RST  input  1  reset, asynchronous, active-low.
- CE  input  1  count-enable tick, one C1K cycle wide.
- LOAD  input  1  capture LOAD_VAL into the counter and the preset register.
- LOAD_VAL  input  8  preset value; [7:4] = tens digit, [3:0] = ones digit, BCD.
- START  input  1  begin or resume counting.
- STOP  input  1  pause counting.
- VAL  output  8  current count, BCD, same digit layout as LOAD_VAL.
- RUNNING  output  1  high while in state RUN.
- DONE  output  1  one-cycle pulse on the cycle the count reaches 00 from RUN.

Behaviour:
- Reset (RST=0, asynchronous):
  - VAL=8'h00, preset=8'h00, state=IDLE, RUNNING=0, DONE=0.
  - Release of RST is synchronous to C1K.
- FSM states: IDLE, RUN, PAUSE, EXPIRED. RUNNING is a registered decode of RUN.
- Input priority within a cycle: LOAD > START > STOP > CE.
- LOAD, accepted in any state:
  - VAL <= clamp(LOAD_VAL) and preset <= the same value, next cycle.
  - clamp: any digit >9 is replaced by 9.
  - Next state is IDLE. Any pending DONE is not generated.
- START:
  - From IDLE or PAUSE with VAL!=00: go to RUN. The first decrement happens on the first CE seen in RUN, i.e. a CE coincident with START is ignored.
  - With VAL==00, or from EXPIRED: ignored, state unchanged.
- STOP: RUN -> PAUSE, VAL held. Ignored in any other state.
- Decrement, only in RUN when CE=1:
  - Ones digit: if ones==0 then ones<=9 and borrow=1; else ones<=ones-1.
  - Tens digit: decrements only on borrow, with the same 0->9 rule.
  - Latency: VAL updates on the C1K edge that samples CE=1.
- Expiry: when a decrement produces 00 (i.e. from 01):
  - DONE=1 for exactly that next cycle, registered and aligned with VAL becoming 00.
  - AUTO_RELOAD=0: state -> EXPIRED, RUNNING=0.
  - AUTO_RELOAD=1: the cycle after DONE, VAL <= preset and the state stays RUN. If preset==00, go to EXPIRED instead.
- EXPIRED: VAL held at 00. Left only via LOAD or reset.
- Wrap-around: the counter never underflows past 00. CE in IDLE, PAUSE or EXPIRED has no effect.
- Reset mid-count: immediate clear to the reset values. No DONE is emitted.
- No combinational path from inputs to outputs. All outputs are registered.

Decomposition:
- Shared package (timer_pkg):
  - State encoding constants: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, EXPIRED=2'd3.
  - BCD_MAX=4'd9.
  - BCD clamp function.
- Sub-module bcd_down_digit:
  - One decade with async active-low reset, load, load value, dec_en, borrow_in, borrow_out and the 4-bit digit.
  - borrow_out = dec_en & borrow_in & (digit==0).
  - Instantiated DIGITS times; the ones digit gets borrow_in=1.
- The top level holds the FSM, the preset register, clamping and DONE generation.

Test Plan:
- Reset/load: RST=0 then 1, LOAD with LOAD_VAL=8'h25 -> VAL=8'h25, RUNNING=0, DONE=0. START plus 3 CE ticks -> VAL=8'h22.
- Borrow: load 8'h10, START, 1 CE -> VAL=8'h09. Load 8'h00 then START -> stays IDLE, RUNNING=0.
- Expiry: load 8'h02, START, 2 CE -> VAL=8'h00 with DONE high exactly 1 cycle. Then state EXPIRED; further CE/START leave VAL=8'h00 and RUNNING=0.
- Pause/priority: load 8'h50, START, 1 CE -> 8'h49. STOP and CE in the same cycle -> VAL stays 8'h49. START and CE in the same cycle -> VAL stays 8'h49. Next CE -> 8'h48.
- Clamp and LOAD priority: LOAD_VAL=8'hAF -> VAL=8'h99. LOAD=1 with START=1 in the same cycle -> IDLE, RUNNING=0.
- AUTO_RELOAD=1: load 8'h03, START, 3 CE -> DONE pulse, then VAL=8'h03 with RUNNING still 1. Assert RST mid-count -> VAL=8'h00 asynchronously and no DONE.
